// File: rtl/ntt_batch_harness.sv
// ntt_batch_harness
// Multi-channel harness for one ntt_memory_wrapper. It holds NCH input and
// reference polynomials (N = 2**LOGN coefficients each) in local memory and
// serves the wrapper's read and write ports. For each channel of a batch it
// raises ntt_start, waits for ntt_finish (or a timeout), then compares the
// captured results against the references.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   ld_*                host load port for input / reference memories (idle only)
//   cmd_start/intt/nch  batch start pulse, mode and channel count (0 or >NCH -> NCH)
//   rd_ch/rd_addr       result readback select; rd_data follows one cycle later
//   busy/done           batch in progress / one-cycle end-of-batch pulse
//   pass/timeout        last-batch verdict, held until the next cmd_start
//   err_count, first_err_ch/addr   mismatch count (saturating) and first location
//   ntt_*               wrapper side: start level, mode, read/write ports, finish
module ntt_batch_harness #(
    parameter int LOGQ    = 64,
    parameter int LOGN    = 4,
    parameter int NCH     = 2,
    parameter int ADDRW   = 10,
    parameter int TIMEOUT = 4096,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int ECW    = LOGN + CHW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en,
    input  logic             ld_ref,
    input  logic [CHW-1:0]   ld_ch,
    input  logic [LOGN-1:0]  ld_addr,
    input  logic [LOGQ-1:0]  ld_data,
    input  logic             cmd_start,
    input  logic             cmd_intt,
    input  logic [CHW:0]     cmd_nch,
    input  logic [CHW-1:0]   rd_ch,
    input  logic [LOGN-1:0]  rd_addr,
    output logic [LOGQ-1:0]  rd_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ECW-1:0]   err_count,
    output logic [CHW-1:0]   first_err_ch,
    output logic [LOGN-1:0]  first_err_addr,
    output logic             ntt_start,
    output logic             ntt_intt,
    input  logic [ADDRW-1:0] ntt_read_address,
    output logic [LOGQ-1:0]  ntt_data_in,
    input  logic [ADDRW-1:0] ntt_write_address,
    input  logic             ntt_wea,
    input  logic [LOGQ-1:0]  ntt_data_out,
    input  logic             ntt_finish
);

    localparam int N    = 1 << LOGN;
    localparam int MEMD = 1 << (CHW + LOGN);
    localparam int TW   = $clog2(TIMEOUT) + 1;
    localparam logic [ADDRW-1:0] N_A      = ADDRW'(N);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [LOGN-1:0]  IDX_LAST = {LOGN{1'b1}};
    localparam logic [CHW:0]     NCH_W    = (CHW + 1)'(NCH);
    localparam logic [ECW-1:0]   ERR_MAX  = {ECW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_GAP   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Saturating increment for the mismatch counter.
    function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] v);
        if (v == ERR_MAX) return v;
        else              return v + ECW'(1);
    endfunction

    // Channel-major memories, indexed {channel, coefficient}.
    logic [LOGQ-1:0] din_mem [MEMD];
    logic [LOGQ-1:0] ref_mem [MEMD];
    logic [LOGQ-1:0] hw_mem  [MEMD];

    state_t          state_r, state_next_s;
    logic [CHW-1:0]  ch_r;
    logic [LOGN-1:0] idx_r;
    logic [TW-1:0]   tmo_r;
    logic [CHW:0]    nch_r;
    logic            intt_r, ntt_start_r, busy_r, done_r, pass_r, timeout_r;
    logic [ECW-1:0]  err_count_r, err_next_s;
    logic [CHW-1:0]  first_err_ch_r;
    logic [LOGN-1:0] first_err_addr_r;
    logic            cmp_valid_r, cmp_mis_r;
    logic [CHW-1:0]  cmp_ch_r;
    logic [LOGN-1:0] cmp_idx_r;
    logic            ch_more_s;
    logic [CHW:0]    nch_clamp_s;
    logic [LOGQ-1:0] ntt_data_in_r, rd_data_r;

    assign rd_data        = rd_data_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign timeout        = timeout_r;
    assign err_count      = err_count_r;
    assign first_err_ch   = first_err_ch_r;
    assign first_err_addr = first_err_addr_r;
    assign ntt_start      = ntt_start_r;
    assign ntt_intt       = intt_r;
    assign ntt_data_in    = ntt_data_in_r;

    // Next-state logic plus the counter/clamp helpers shared with the registers.
    always_comb begin
        state_next_s = state_r;
        ch_more_s    = ({1'b0, ch_r} + (CHW + 1)'(1)) < nch_r;
        if (cmp_valid_r && cmp_mis_r) err_next_s = sat_inc(err_count_r);
        else                          err_next_s = err_count_r;
        if (cmd_nch == {(CHW + 1){1'b0}} || cmd_nch > NCH_W) nch_clamp_s = NCH_W;
        else                                                 nch_clamp_s = cmd_nch;
        case (state_r)
            S_IDLE: begin
                if (cmd_start) state_next_s = S_RUN;
                else           state_next_s = S_IDLE;
            end
            S_RUN: begin
                // A finish arriving on the timeout boundary still counts as a finish.
                if (ntt_finish)              state_next_s = S_GAP;
                else if (tmo_r == TMO_LAST)  state_next_s = S_DONE;
                else                         state_next_s = S_RUN;
            end
            S_GAP:   state_next_s = S_CHECK;
            S_CHECK: begin
                if (idx_r == IDX_LAST) begin
                    if (ch_more_s) state_next_s = S_RUN;
                    else           state_next_s = S_DONE;
                end else begin
                    state_next_s = S_CHECK;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register, batch control, compare pipeline and verdict registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= S_IDLE;
            ch_r             <= {CHW{1'b0}};
            idx_r            <= {LOGN{1'b0}};
            tmo_r            <= {TW{1'b0}};
            nch_r            <= {(CHW + 1){1'b0}};
            intt_r           <= 1'b0;
            ntt_start_r      <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            timeout_r        <= 1'b0;
            err_count_r      <= {ECW{1'b0}};
            first_err_ch_r   <= {CHW{1'b0}};
            first_err_addr_r <= {LOGN{1'b0}};
            cmp_valid_r      <= 1'b0;
            cmp_mis_r        <= 1'b0;
            cmp_ch_r         <= {CHW{1'b0}};
            cmp_idx_r        <= {LOGN{1'b0}};
        end else begin
            state_r     <= state_next_s;
            busy_r      <= (state_next_s != S_IDLE);
            done_r      <= (state_next_s == S_DONE);
            ntt_start_r <= (state_next_s == S_RUN);
            // Stage 1 compares one coefficient; stage 2 (below) accounts for it.
            // The last compare of a channel drains during the following state.
            cmp_valid_r <= (state_r == S_CHECK);
            cmp_mis_r   <= (hw_mem[{ch_r, idx_r}] != ref_mem[{ch_r, idx_r}]);
            cmp_ch_r    <= ch_r;
            cmp_idx_r   <= idx_r;
            err_count_r <= err_next_s;
            if (cmp_valid_r && cmp_mis_r && err_count_r == {ECW{1'b0}}) begin
                first_err_ch_r   <= cmp_ch_r;
                first_err_addr_r <= cmp_idx_r;
            end
            case (state_r)
                S_IDLE: begin
                    if (cmd_start) begin
                        intt_r           <= cmd_intt;
                        nch_r            <= nch_clamp_s;
                        ch_r             <= {CHW{1'b0}};
                        tmo_r            <= {TW{1'b0}};
                        err_count_r      <= {ECW{1'b0}};
                        timeout_r        <= 1'b0;
                        pass_r           <= 1'b0;
                        first_err_ch_r   <= {CHW{1'b0}};
                        first_err_addr_r <= {LOGN{1'b0}};
                    end
                end
                S_RUN: begin
                    if (!ntt_finish) begin
                        if (tmo_r == TMO_LAST) timeout_r <= 1'b1;
                        else                   tmo_r     <= tmo_r + TW'(1);
                    end
                end
                S_GAP:   idx_r <= {LOGN{1'b0}};
                S_CHECK: begin
                    idx_r <= idx_r + LOGN'(1);
                    if (idx_r == IDX_LAST && ch_more_s) begin
                        ch_r  <= ch_r + CHW'(1);
                        tmo_r <= {TW{1'b0}};
                    end
                end
                S_DONE:  pass_r <= !timeout_r && (err_next_s == {ECW{1'b0}});
                default: ;
            endcase
        end
    end

    // Memory writes: host loads only while idle, wrapper results only in RUN.
    always_ff @(posedge clk) begin
        if (state_r == S_IDLE && ld_en) begin
            if (ld_ref) ref_mem[{ld_ch, ld_addr}] <= ld_data;
            else        din_mem[{ld_ch, ld_addr}] <= ld_data;
        end
        if (state_r == S_RUN && ntt_wea && ntt_write_address < N_A) begin
            hw_mem[{ch_r, ntt_write_address[LOGN-1:0]}] <= ntt_data_out;
        end
    end

    // Registered read ports: wrapper input data and host result readback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ntt_data_in_r <= {LOGQ{1'b0}};
            rd_data_r     <= {LOGQ{1'b0}};
        end else begin
            if (ntt_read_address < N_A) ntt_data_in_r <= din_mem[{ch_r, ntt_read_address[LOGN-1:0]}];
            else                        ntt_data_in_r <= {LOGQ{1'b0}};
            rd_data_r <= hw_mem[{rd_ch, rd_addr}];
        end
    end

endmodule

// File: tb/tb_ntt_batch_harness.sv
// Self-checking bench for ntt_batch_harness. A behavioural NTT core stand-in
// reads each channel's input through the wrapper port and writes it back in
// reversed order; the bench's model predicts results, mismatch counts and
// verdicts from the loaded polynomials.
module tb_ntt_batch_harness;
    localparam int LOGQ = 64, LOGN = 4, NCH = 2, ADDRW = 10, TMO = 64;
    localparam int N = 16, CHW = 1, ECW = LOGN + CHW + 1;

    logic clk = 1'b0, rst = 1'b0;
    logic ld_en = 1'b0, ld_ref = 1'b0, cmd_start = 1'b0, cmd_intt = 1'b0;
    logic [CHW-1:0] ld_ch = '0, rd_ch = '0;
    logic [LOGN-1:0] ld_addr = '0, rd_addr = '0;
    logic [LOGQ-1:0] ld_data = '0, ntt_data_out = '0;
    logic [CHW:0] cmd_nch = '0;
    logic [ADDRW-1:0] ntt_read_address = '0, ntt_write_address = '0;
    logic ntt_wea = 1'b0, ntt_finish = 1'b0;
    logic [LOGQ-1:0] rd_data, ntt_data_in;
    logic busy, done, pass, timeout, ntt_start, ntt_intt;
    logic [ECW-1:0] err_count;
    logic [CHW-1:0] first_err_ch;
    logic [LOGN-1:0] first_err_addr;

    ntt_batch_harness #(.LOGQ(LOGQ), .LOGN(LOGN), .NCH(NCH), .ADDRW(ADDRW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_ref(ld_ref), .ld_ch(ld_ch), .ld_addr(ld_addr),
        .ld_data(ld_data), .cmd_start(cmd_start), .cmd_intt(cmd_intt), .cmd_nch(cmd_nch),
        .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .err_count(err_count), .first_err_ch(first_err_ch),
        .first_err_addr(first_err_addr), .ntt_start(ntt_start), .ntt_intt(ntt_intt),
        .ntt_read_address(ntt_read_address), .ntt_data_in(ntt_data_in),
        .ntt_write_address(ntt_write_address), .ntt_wea(ntt_wea),
        .ntt_data_out(ntt_data_out), .ntt_finish(ntt_finish));

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int start_rises = 0;
    logic start_prev = 1'b0;
    logic [LOGQ-1:0] din_m [2][16];
    logic [LOGQ-1:0] ref_m [2][16];
    logic [LOGQ-1:0] hw_m  [2][16];

    // Count rising edges of ntt_start as seen at each clock edge.
    always @(posedge clk) begin
        start_prev <= ntt_start;
        if (ntt_start && !start_prev) start_rises <= start_rises + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit isref, input int ch, input int a, input logic [63:0] v);
        ld_en = 1'b1; ld_ref = isref; ld_ch = CHW'(ch); ld_addr = LOGN'(a); ld_data = v;
        tick;
        ld_en = 1'b0;
    endtask

    task automatic start_batch(input bit intt, input int nch);
        cmd_start = 1'b1; cmd_intt = intt; cmd_nch = (CHW + 1)'(nch);
        tick;
        cmd_start = 1'b0;
    endtask

    // Behavioural core: read the channel, write it back reversed, then finish.
    task automatic run_core(input int ch, input bit intt, input bit probe);
        logic [63:0] buffer [16];
        for (int w = 0; w < 200 && ntt_start !== 1'b1; w++) tick;
        check("start_seen", 64'(ntt_start), 64'd1);
        check("intt_mode", 64'(ntt_intt), 64'(intt));
        for (int k = 0; k < N; k++) begin
            ntt_read_address = ADDRW'(k);
            tick;
            buffer[k] = ntt_data_in;
        end
        check("data_in_0", ntt_data_in === 64'hx ? 64'd0 : buffer[0], din_m[ch][0]);
        check("data_in_last", buffer[N-1], din_m[ch][N-1]);
        if (probe) begin
            ntt_read_address = ADDRW'(16);
            tick;
            check("read_oob", ntt_data_in, 64'd0);
        end
        for (int k = 0; k < N; k++) begin
            ntt_wea = 1'b1; ntt_write_address = ADDRW'(k); ntt_data_out = buffer[N-1-k];
            hw_m[ch][k] = din_m[ch][N-1-k];
            tick;
        end
        if (probe) begin
            ntt_write_address = ADDRW'(20); ntt_data_out = {$urandom, $urandom};
            tick;
        end
        ntt_wea = 1'b0;
        check("intt_held", 64'(ntt_intt), 64'(intt));
        check("start_held", 64'(ntt_start), 64'd1);
        ntt_finish = 1'b1;
        tick;
        ntt_finish = 1'b0;
    endtask

    task automatic wait_done(output int ticks);
        ticks = 0;
        while (done !== 1'b1 && ticks < 200) begin
            tick;
            ticks++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    // Compare verdict outputs against the model, one cycle after done.
    task automatic check_result(input int nch_run, input bit tmo);
        int errs = 0, fc = 0, fa = 0;
        bit found = 1'b0;
        if (!tmo) begin
            for (int c = 0; c < nch_run; c++)
                for (int a = 0; a < N; a++)
                    if (hw_m[c][a] !== ref_m[c][a]) begin
                        if (!found) begin fc = c; fa = a; found = 1'b1; end
                        errs++;
                    end
        end
        check("err_count", 64'(err_count), 64'(errs));
        check("pass", 64'(pass), 64'(errs == 0 && !tmo));
        check("timeout", 64'(timeout), 64'(tmo));
        check("first_err_ch", 64'(first_err_ch), 64'(fc));
        check("first_err_addr", 64'(first_err_addr), 64'(fa));
        check("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int ticks, r0, cnt;
        logic [63:0] v;
        // Reset state
        repeat (3) tick;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(ntt_start), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_data_in", ntt_data_in, 64'd0);
        rst = 1'b1;
        tick;
        // Load random inputs; references are the reversed inputs
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < N; a++) begin
                din_m[c][a] = {$urandom, $urandom};
                load(1'b0, c, a, din_m[c][a]);
            end
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < N; a++) begin
                ref_m[c][a] = din_m[c][N-1-a];
                load(1'b1, c, a, ref_m[c][a]);
            end
        // T2: forward, one channel, all match
        start_batch(1'b0, 1);
        check("busy_run", 64'(busy), 64'd1);
        run_core(0, 1'b0, 1'b0);
        wait_done(ticks);
        check("done_latency", 64'(ticks + 1), 64'(N + 2));
        check("busy_in_done", 64'(busy), 64'd1);
        tick;
        check_result(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            int a = $urandom_range(N - 1);
            rd_ch = 1'b0; rd_addr = LOGN'(a);
            tick;
            check("readback", rd_data, hw_m[0][a]);
        end
        // T3: two channels with one corrupted reference coefficient
        ref_m[1][5] = ref_m[1][5] ^ 64'd1;
        load(1'b1, 1, 5, ref_m[1][5]);
        r0 = start_rises;
        start_batch(1'b0, 2);
        run_core(0, 1'b0, 1'b0);
        run_core(1, 1'b0, 1'b0);
        wait_done(ticks);
        tick;
        check_result(2, 1'b0);
        check("start_pulses_2ch", 64'(start_rises - r0), 64'd2);
        // T4: core never finishes
        start_batch(1'b0, 1);
        cnt = 0;
        while (ntt_start === 1'b1 && cnt < 200) begin
            tick;
            cnt++;
        end
        check("start_high_cycles", 64'(cnt), 64'(TMO));
        check("tmo_done", 64'(done), 64'd1);
        tick;
        check_result(1, 1'b1);
        // T5: commands and loads during busy are ignored; cmd_nch=0 runs NCH
        r0 = start_rises;
        start_batch(1'b0, 0);
        cmd_start = 1'b1; ld_en = 1'b1; ld_ref = 1'b0; ld_ch = 1'b0; ld_addr = '0;
        ld_data = ~din_m[0][0];
        tick;
        cmd_start = 1'b0; ld_en = 1'b0;
        run_core(0, 1'b0, 1'b0);
        run_core(1, 1'b0, 1'b0);
        wait_done(ticks);
        tick;
        check_result(2, 1'b0);
        check("start_pulses_nch0", 64'(start_rises - r0), 64'd2);
        tick;
        check("no_restart", 64'(busy), 64'd0);
        // T6: load in the start cycle, inverse mode, out-of-range accesses
        ref_m[0][0] = ref_m[0][0] ^ 64'd2;
        ld_en = 1'b1; ld_ref = 1'b1; ld_ch = 1'b0; ld_addr = '0; ld_data = ref_m[0][0];
        cmd_start = 1'b1; cmd_intt = 1'b1; cmd_nch = 2'd1;
        tick;
        ld_en = 1'b0; cmd_start = 1'b0;
        run_core(0, 1'b1, 1'b1);
        wait_done(ticks);
        tick;
        check_result(1, 1'b0);
        v = {$urandom, $urandom};
        ntt_wea = 1'b1; ntt_write_address = ADDRW'(3); ntt_data_out = v;
        tick;
        ntt_wea = 1'b0;
        rd_ch = 1'b0; rd_addr = LOGN'(3);
        tick;
        check("idle_write_dropped", rd_data, hw_m[0][3]);
        // T1: asynchronous reset in the middle of RUN
        start_batch(1'b0, 1);
        repeat (5) tick;
        check("pre_rst_start", 64'(ntt_start), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_start", 64'(ntt_start), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_pass", 64'(pass), 64'd0);
        check("arst_err", 64'(err_count), 64'd0);
        tick;
        rst = 1'b1;
        repeat (3) tick;
        check("post_rst_idle", 64'(busy), 64'd0);
        check("post_rst_start", 64'(ntt_start), 64'd0);
        check("mem_retained", rd_data, hw_m[0][3]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
